// File: rtl/sl_pkg.sv
// Shared types and helpers for the queued SL line transmitter.
package sl_pkg;

    // Widest word the line protocol carries.
    localparam int unsigned SL_MAX_BITS = 32;

    // Per-word length selector stored alongside each queued word.
    typedef enum logic [1:0] {
        SL_MODE_8   = 2'b00,
        SL_MODE_16  = 2'b01,
        SL_MODE_32  = 2'b10,
        SL_MODE_32B = 2'b11
    } sl_mode_t;

    // Serialiser states.
    typedef enum logic [2:0] {
        TX_IDLE      = 3'd0,
        TX_LOW       = 3'd1,
        TX_HIGH      = 3'd2,
        TX_STOP_LOW  = 3'd3,
        TX_STOP_HIGH = 3'd4
    } tx_state_t;

    // Number of data bits sent for a given mode.
    function automatic int unsigned mode_bits(input sl_mode_t mode);
        case (mode)
            SL_MODE_8:  return 8;
            SL_MODE_16: return 16;
            default:    return 32;
        endcase
    endfunction

    // Parity bit over data[n-1:0]; odd=1 makes data+parity carry an odd count of ones.
    function automatic logic parity_bit(input logic [SL_MAX_BITS-1:0] data,
                                        input int unsigned n,
                                        input logic odd);
        logic [SL_MAX_BITS-1:0] mask;
        mask = (n >= SL_MAX_BITS) ? '1 : ((32'd1 << n) - 32'd1);
        return odd ^ (^(data & mask));
    endfunction

endpackage

// File: rtl/sl_sync_fifo.sv
// Single-clock FIFO with level/full/empty flags; power-of-two depth so pointers wrap naturally.
module sl_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == FULL_LEVEL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array: written on accepted pushes, no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/sl_tx_queue.sv
// Queued SL line driver: words enter a FIFO and are serialised MSB first on sl0/sl1,
// followed by a parity symbol and a stop symbol. Line outputs are registered from the
// current state, so the line trails the state register by one cycle.
//
// Write port handshake: a word (wr_data, wr_mode) transfers on any rising clk edge where
// wr_valid && wr_ready; wr_ready is simply !fifo_full and does not depend on wr_valid.
module sl_tx_queue
    import sl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 8,
    parameter int PARITY_ODD = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [1:0]                    wr_mode,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          cfg_half_period,
    output logic                          sl0,
    output logic                          sl1,
    output logic                          busy,
    output logic                          word_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output tx_state_t                     dbg_state
);

    localparam int EW = DATA_WIDTH + 2;

    tx_state_t              r_state;
    tx_state_t              w_state_next;
    logic                   w_pop;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic [EW-1:0]          w_rd_entry;
    logic [DATA_WIDTH-1:0]  w_rd_data;
    sl_mode_t               w_rd_mode;
    logic [31:0]            w_data32;
    int unsigned            w_n;
    logic [DIV_WIDTH-1:0]   w_h;
    logic                   w_parity;
    logic                   w_phase_end;
    logic                   w_bit;
    logic                   w_sl0_next;
    logic                   w_sl1_next;

    logic [31:0]            r_shift;
    logic [4:0]             r_bitcnt;
    logic                   r_par;
    logic                   r_pbit;
    logic [DIV_WIDTH-1:0]   r_half;
    logic [DIV_WIDTH-1:0]   r_cnt;
    logic                   r_sl0;
    logic                   r_sl1;
    logic                   r_busy;
    logic                   r_done;

    sl_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_push  (wr_valid),
        .i_data  ({wr_mode, wr_data}),
        .i_pop   (w_pop),
        .o_data  (w_rd_entry),
        .o_level (fifo_level),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign fifo_empty  = w_fifo_empty;
    assign fifo_full   = w_fifo_full;
    assign wr_ready    = !w_fifo_full;
    assign w_rd_data   = w_rd_entry[DATA_WIDTH-1:0];
    assign w_rd_mode   = sl_mode_t'(w_rd_entry[EW-1:DATA_WIDTH]);
    assign w_data32    = 32'(w_rd_data);
    assign w_h         = (cfg_half_period == '0) ? DIV_WIDTH'(1) : cfg_half_period;
    assign w_phase_end = (r_cnt == '0);
    assign w_bit       = r_par ? r_pbit : r_shift[r_bitcnt];
    assign w_parity    = parity_bit(w_data32, w_n, (PARITY_ODD != 0));

    assign sl0         = r_sl0;
    assign sl1         = r_sl1;
    assign busy        = r_busy;
    assign word_done   = r_done;
    assign dbg_state   = r_state;

    // Word length from the stored mode, clamped to the configured data width.
    always_comb begin
        w_n = mode_bits(w_rd_mode);
        if (w_n > DATA_WIDTH) begin
            w_n = DATA_WIDTH;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: each phase lasts until the half-period counter reaches zero.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (enable && !w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = TX_LOW;
                end
            end
            TX_LOW: begin
                if (w_phase_end) begin
                    w_state_next = TX_HIGH;
                end
            end
            TX_HIGH: begin
                if (w_phase_end) begin
                    w_state_next = r_par ? TX_STOP_LOW : TX_LOW;
                end
            end
            TX_STOP_LOW: begin
                if (w_phase_end) begin
                    w_state_next = TX_STOP_HIGH;
                end
            end
            TX_STOP_HIGH: begin
                if (w_phase_end) begin
                    w_state_next = TX_IDLE;
                end
            end
            default: w_state_next = TX_IDLE;
        endcase
    end

    // Line levels for the current state: a bit pulls one line low, stop pulls both.
    always_comb begin
        w_sl0_next = 1'b1;
        w_sl1_next = 1'b1;
        case (r_state)
            TX_LOW: begin
                w_sl0_next = w_bit;
                w_sl1_next = !w_bit;
            end
            TX_STOP_LOW: begin
                w_sl0_next = 1'b0;
                w_sl1_next = 1'b0;
            end
            default: ;
        endcase
    end

    // Word datapath: latch data, length, parity and H at pop; step counters per phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_par    <= 1'b0;
            r_pbit   <= 1'b0;
            r_half   <= DIV_WIDTH'(1);
            r_cnt    <= '0;
        end else if (w_pop) begin
            r_shift  <= w_data32;
            r_bitcnt <= 5'(w_n - 1);
            r_par    <= 1'b0;
            r_pbit   <= w_parity;
            r_half   <= w_h;
            r_cnt    <= w_h - 1'b1;
        end else if (r_state != TX_IDLE) begin
            if (w_phase_end) begin
                r_cnt <= r_half - 1'b1;
                if (r_state == TX_HIGH && !r_par) begin
                    if (r_bitcnt == '0) begin
                        r_par <= 1'b1;
                    end else begin
                        r_bitcnt <= r_bitcnt - 1'b1;
                    end
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Registered line and status outputs; word_done lands on the final stop-high line cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sl0  <= 1'b1;
            r_sl1  <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_sl0  <= w_sl0_next;
            r_sl1  <= w_sl1_next;
            r_busy <= (w_state_next != TX_IDLE);
            r_done <= (r_state == TX_STOP_HIGH) && w_phase_end;
        end
    end

endmodule

// File: tb/tb_sl_tx_queue.sv
// Directed bench for sl_tx_queue: an odd-parity and an even-parity instance share all
// inputs; per-cycle expected {busy, word_done, sl1, sl0} traces are built from a small
// protocol model and compared at each falling clock edge.
module tb_sl_tx_queue;
    import sl_pkg::*;

    // Clock and stimulus signals.
    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic [1:0]  wr_mode;
    logic        enable;
    logic [7:0]  cfg_half_period;

    // Odd-parity instance outputs.
    logic        wr_ready, sl0, sl1, busy, word_done, fifo_empty, fifo_full;
    logic [2:0]  fifo_level;
    tx_state_t   dbg_state;

    // Even-parity instance outputs.
    logic        wr_ready_e, sl0_e, sl1_e, busy_e, word_done_e, fifo_empty_e, fifo_full_e;
    logic [2:0]  fifo_level_e;
    tx_state_t   dbg_state_e;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected per-cycle {busy, word_done, sl1, sl0}.
    logic [3:0] exp_q[$];
    logic [3:0] exp_e_q[$];

    sl_tx_queue #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .DIV_WIDTH(8), .PARITY_ODD(1)) u_dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_mode(wr_mode), .enable(enable),
        .cfg_half_period(cfg_half_period), .sl0(sl0), .sl1(sl1), .busy(busy),
        .word_done(word_done), .fifo_level(fifo_level), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .dbg_state(dbg_state)
    );

    sl_tx_queue #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .DIV_WIDTH(8), .PARITY_ODD(0)) u_dut_even (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_e),
        .wr_data(wr_data), .wr_mode(wr_mode), .enable(enable),
        .cfg_half_period(cfg_half_period), .sl0(sl0_e), .sl1(sl1_e), .busy(busy_e),
        .word_done(word_done_e), .fifo_level(fifo_level_e), .fifo_empty(fifo_empty_e),
        .fifo_full(fifo_full_e), .dbg_state(dbg_state_e)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Offer one word for one clock edge; returns at the following falling edge.
    task automatic push_word(input logic [31:0] d, input logic [1:0] m);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_mode  = m;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic qpush(input int k, input logic [3:0] v);
        if (k == 0) exp_q.push_back(v);
        else        exp_e_q.push_back(v);
    endtask

    task automatic add_idle(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back(4'b0011);
            exp_e_q.push_back(4'b0011);
        end
    endtask

    // Model of one word: the pop cycle (busy, line high), n data bits MSB first, parity, stop.
    task automatic add_word(input logic [31:0] d, input int n, input int h);
        logic [31:0] masked;
        logic [31:0] tmp;
        int          ones;
        logic        par;
        logic        bit_v;
        masked = (n >= 32) ? d : (d & ((32'd1 << n) - 32'd1));
        ones   = $countones(masked);
        for (int k = 0; k < 2; k++) begin
            par = (k == 0) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            qpush(k, 4'b1011);
            for (int s = 0; s <= n; s++) begin
                if (s < n) begin
                    tmp   = masked >> (n - 1 - s);
                    bit_v = tmp[0];
                end else begin
                    bit_v = par;
                end
                repeat (h) qpush(k, bit_v ? 4'b1001 : 4'b1010);
                repeat (h) qpush(k, 4'b1011);
            end
            repeat (h) qpush(k, 4'b1000);
            repeat (h - 1) qpush(k, 4'b1011);
            qpush(k, 4'b0111);
        end
    endtask

    // Compare up to cnt expected cycles, advancing one falling edge per cycle.
    task automatic run_check(input string tag, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (exp_q.size() == 0 || exp_e_q.size() == 0) break;
            check($sformatf("%s_odd[%0d]", tag, i),
                  32'({busy, word_done, sl1, sl0}), 32'(exp_q.pop_front()));
            check($sformatf("%s_even[%0d]", tag, i),
                  32'({busy_e, word_done_e, sl1_e, sl0_e}), 32'(exp_e_q.pop_front()));
            @(negedge clk);
        end
    endtask

    task automatic run_all(input string tag);
        run_check(tag, exp_q.size());
    endtask

    initial begin
        reset           = 1'b1;
        wr_valid        = 1'b0;
        wr_data         = '0;
        wr_mode         = 2'b00;
        enable          = 1'b0;
        cfg_half_period = 8'd2;
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst_sl0",        32'(sl0),        32'd1);
        check("rst_sl1",        32'(sl1),        32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_word_done",  32'(word_done),  32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        check("rst_fifo_full",  32'(fifo_full),  32'd0);
        check("rst_wr_ready",   32'(wr_ready),   32'd1);
        check("rst_state",      32'(dbg_state),  32'(TX_IDLE));
        check("rst_even_flags",
              32'({wr_ready_e, fifo_empty_e, fifo_full_e, fifo_level_e, sl1_e, sl0_e, busy_e, word_done_e}),
              32'({1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
        check("rst_even_state", 32'(dbg_state_e), 32'(TX_IDLE));
        reset = 1'b0;
        @(negedge clk);

        // 8-bit 0xA5, H=2: first low two edges after the push edge, 40-cycle word.
        enable          = 1'b1;
        cfg_half_period = 8'd2;
        push_word(32'h0000_00A5, 2'b00);
        add_idle(1);
        add_word(32'h0000_00A5, 8, 2);
        run_all("a5");

        // 32-bit all ones, H=1: 68-cycle word.
        cfg_half_period = 8'd1;
        push_word(32'hFFFF_FFFF, 2'b10);
        add_idle(1);
        add_word(32'hFFFF_FFFF, 32, 1);
        run_all("ones32");

        // Fill the FIFO with enable low; a fifth offer must be refused.
        enable = 1'b0;
        push_word(32'h0000_003C, 2'b00);
        push_word(32'hFFFF_0F0F, 2'b01);
        push_word(32'h8000_0001, 2'b10);
        push_word(32'h1234_5678, 2'b11);
        check("full_level",    32'(fifo_level), 32'd4);
        check("full_flag",     32'(fifo_full),  32'd1);
        check("full_wr_ready", 32'(wr_ready),   32'd0);
        check("full_empty",    32'(fifo_empty), 32'd0);
        check("full_busy",     32'(busy),       32'd0);
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_BEEF;
        wr_mode  = 2'b00;
        @(negedge clk);
        wr_valid = 1'b0;
        check("overflow_level", 32'(fifo_level), 32'd4);

        // Drain back-to-back; the refused word must never appear on the line.
        enable = 1'b1;
        add_idle(1);
        add_word(32'h0000_003C, 8, 1);
        add_word(32'hFFFF_0F0F, 16, 1);
        add_word(32'h8000_0001, 32, 1);
        add_word(32'h1234_5678, 32, 1);
        add_idle(3);
        run_all("fill");
        check("drain_empty", 32'(fifo_empty), 32'd1);
        check("drain_level", 32'(fifo_level), 32'd0);

        // Push and pop on the same edge with two words held.
        enable = 1'b0;
        push_word(32'h0000_0011, 2'b00);
        push_word(32'h0000_0080, 2'b00);
        check("pp_level_before", 32'(fifo_level), 32'd2);
        enable   = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'h0000_00FF;
        wr_mode  = 2'b00;
        @(negedge clk);
        wr_valid = 1'b0;
        check("pp_level_after", 32'(fifo_level), 32'd2);
        add_word(32'h0000_0011, 8, 1);
        add_word(32'h0000_0080, 8, 1);
        add_word(32'h0000_00FF, 8, 1);
        add_idle(2);
        run_all("pushpop");

        // Half-period changed mid-word: 3 for the first word, 1 for the next, 0 acts as 1.
        enable          = 1'b0;
        cfg_half_period = 8'd3;
        push_word(32'h0000_005A, 2'b00);
        push_word(32'h0000_00C3, 2'b00);
        push_word(32'h0000_0096, 2'b00);
        enable = 1'b1;
        add_idle(1);
        add_word(32'h0000_005A, 8, 3);
        add_word(32'h0000_00C3, 8, 1);
        add_word(32'h0000_0096, 8, 1);
        add_idle(2);
        run_check("hchg", 20);
        cfg_half_period = 8'd1;
        run_check("hchg", 48);
        cfg_half_period = 8'd0;
        run_all("hchg");

        // Reset in the middle of a 16-bit word with another word queued.
        enable          = 1'b0;
        cfg_half_period = 8'd2;
        push_word(32'h0000_1234, 2'b01);
        push_word(32'h0000_00FF, 2'b00);
        check("mid_level", 32'(fifo_level), 32'd2);
        enable = 1'b1;
        add_idle(1);
        add_word(32'h0000_1234, 16, 2);
        run_check("mid", 3);
        check("mid_low_sl0", 32'(sl0), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_sl0",   32'(sl0),        32'd1);
        check("mid_rst_sl1",   32'(sl1),        32'd1);
        check("mid_rst_busy",  32'(busy),       32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_even_lines", 32'({sl1_e, sl0_e}), 32'd3);
        exp_q.delete();
        exp_e_q.delete();
        @(negedge clk);
        reset = 1'b0;
        add_idle(20);
        run_all("post_rst");
        check("post_rst_empty", 32'(fifo_empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
